// File: rtl/aes_axis_pkg.sv
// Types and helpers shared by the AES-256 CTR AXI-Stream framer.
package aes_axis_pkg;

`include "aes_defines.svh"

    localparam int KEY_BITS   = `AES256_KEY_LENGTH;
    localparam int BLOCK_BITS = `AES_BLOCK_SIZE;
    localparam int KEEP_MAX_W = BLOCK_BITS / 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_KEY     = 4'b0010,
        ST_IV      = 4'b0100,
        ST_PAYLOAD = 4'b1000
    } framer_state_t;

    // True when keep is a low-order run of ones (all zeros included).
    function automatic logic keep_contiguous(input logic [KEEP_MAX_W-1:0] keep);
        logic [KEEP_MAX_W-1:0] inc_v;
        inc_v = keep + {{(KEEP_MAX_W-1){1'b0}}, 1'b1};
        return ((keep & inc_v) == {KEEP_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle with tuser carrying the encrypt/decrypt mode.
interface axis_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tkeep;
    logic               tlast;
    logic               tuser;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tkeep, output tlast, output tuser,
                    output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tuser,
                    input tvalid, output tready);
endinterface

// File: rtl/aes_defines.svh
// Shared AES size constants: key and block lengths in bits.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES256_KEY_LENGTH 256
`define AES_BLOCK_SIZE    128

`endif

// File: rtl/aes_field_serializer.sv
// Holds one wide field (key or IV) and presents the AXIS-sized word selected by idx.
module aes_field_serializer #(
    parameter int FIELD_WIDTH = 256,
    parameter int AXIS_WIDTH  = 8,
    localparam int WORDS      = FIELD_WIDTH / AXIS_WIDTH,
    localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   load,
    input  logic [FIELD_WIDTH-1:0] field,
    input  logic [IDX_W-1:0]       idx,
    output logic [AXIS_WIDTH-1:0]  word
);

    logic [WORDS-1:0][AXIS_WIDTH-1:0] field_r;

    // Capture the field when a new message is accepted.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            field_r <= '0;
        end else if (load) begin
            field_r <= field;
        end else begin
            field_r <= field_r;
        end
    end

    assign word = field_r[idx];

endmodule

// File: rtl/aes256_ctr_axis_framer.sv
// Frames key words, IV words and the payload into one AXIS message for the AES-256 CTR core.
// Optional tkeep checker: define AES_FRAMER_KEEP_CHECK_EN to drive Error.
module aes256_ctr_axis_framer
    import aes_axis_pkg::*;
#(
    parameter int AXIS_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [KEY_BITS-1:0]   Key,
    input  logic [BLOCK_BITS-1:0] Iv,
    input  logic                  Encrypt,
    output logic                  Idle,
    output logic                  Error,
    axis_if.slave                 S_axis,
    axis_if.master                M_axis
);

    localparam int KEEP_W    = AXIS_WIDTH / 8;
    localparam int KEY_WORDS = KEY_BITS / AXIS_WIDTH;
    localparam int IV_WORDS  = BLOCK_BITS / AXIS_WIDTH;
    localparam int KEY_IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int IV_IDX_W  = (IV_WORDS > 1) ? $clog2(IV_WORDS) : 1;
    localparam int CNT_W     = KEY_IDX_W;

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_WORDS - 1);
    localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(IV_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    framer_state_t           state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    encrypt_r;
    logic                    load_s;
    logic [AXIS_WIDTH-1:0]   key_word_s, iv_word_s;
    logic                    m_tvalid_s, m_tlast_s, s_tready_s;
    logic [AXIS_WIDTH-1:0]   m_tdata_s;
    logic [KEEP_W-1:0]       m_tkeep_s;

    aes_field_serializer #(
        .FIELD_WIDTH (KEY_BITS),
        .AXIS_WIDTH  (AXIS_WIDTH)
    ) u_key_ser (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (load_s),
        .field (Key),
        .idx   (cnt_r[KEY_IDX_W-1:0]),
        .word  (key_word_s)
    );

    aes_field_serializer #(
        .FIELD_WIDTH (BLOCK_BITS),
        .AXIS_WIDTH  (AXIS_WIDTH)
    ) u_iv_ser (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (load_s),
        .field (Iv),
        .idx   (cnt_r[IV_IDX_W-1:0]),
        .word  (iv_word_s)
    );

    // State, word counter and captured mode bit.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            encrypt_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            encrypt_r <= load_s ? Encrypt : encrypt_r;
        end
    end

    // Next state and stream outputs; the counter only moves on an M handshake.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        load_s     = 1'b0;
        m_tvalid_s = 1'b0;
        m_tdata_s  = '0;
        m_tkeep_s  = '0;
        m_tlast_s  = 1'b0;
        s_tready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    load_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_KEY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_KEY: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = key_word_s;
                m_tkeep_s  = '1;
                if (M_axis.tready) begin
                    if (cnt_r == KEY_LAST) begin
                        cnt_s   = '0;
                        state_s = ST_IV;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_IV: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = iv_word_s;
                m_tkeep_s  = '1;
                if (M_axis.tready) begin
                    if (cnt_r == IV_LAST) begin
                        cnt_s   = '0;
                        state_s = ST_PAYLOAD;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PAYLOAD: begin
                m_tvalid_s = S_axis.tvalid;
                m_tdata_s  = S_axis.tdata;
                m_tkeep_s  = S_axis.tkeep;
                m_tlast_s  = S_axis.tlast;
                s_tready_s = M_axis.tready;
                if (S_axis.tvalid && M_axis.tready && S_axis.tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    assign M_axis.tvalid = m_tvalid_s;
    assign M_axis.tdata  = m_tdata_s;
    assign M_axis.tkeep  = m_tkeep_s;
    assign M_axis.tlast  = m_tlast_s;
    assign M_axis.tuser  = encrypt_r;
    assign S_axis.tready = s_tready_s;
    assign Idle          = (state_r == ST_IDLE);

`ifdef AES_FRAMER_KEEP_CHECK_EN
    logic error_r;
    logic keep_bad_s;

    // Flag payload beats whose tkeep cannot be a legal AES input beat.
    always_comb begin
        keep_bad_s = 1'b0;
        if ((state_r == ST_PAYLOAD) && S_axis.tvalid && M_axis.tready) begin
            if (S_axis.tlast) begin
                keep_bad_s = !keep_contiguous(KEEP_MAX_W'(S_axis.tkeep));
            end else begin
                keep_bad_s = (S_axis.tkeep != {KEEP_W{1'b1}});
            end
        end else begin
            keep_bad_s = 1'b0;
        end
    end

    // Sticky error, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            error_r <= 1'b0;
        end else if (keep_bad_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    assign Error = error_r;
`else
    assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_aes256_ctr_axis_framer.sv
// Directed bench for aes256_ctr_axis_framer at AXIS_WIDTH 8 and 32.
module tb_aes256_ctr_axis_framer;

    logic         clk = 1'b0;
    logic         rst, start8, start32, encrypt;
    logic [255:0] key;
    logic [127:0] iv;
    logic         idle8, err8, idle32, err32;

    int checks = 0;
    int errors = 0;

`ifdef AES_FRAMER_KEEP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic [7:0]  expb [0:127];
    logic [10:0] q8 [$];
    logic [37:0] q32 [$];
    bit          pat3 [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  exp3 [0:4] = '{8'h40, 8'h41, 8'h41, 8'h41, 8'h42};

    axis_if #(.WIDTH(8))  s8 ();
    axis_if #(.WIDTH(8))  m8 ();
    axis_if #(.WIDTH(32)) s32 ();
    axis_if #(.WIDTH(32)) m32 ();

    always #5 clk = ~clk;

    aes256_ctr_axis_framer #(.AXIS_WIDTH(8)) dut8 (
        .Clk(clk), .Rst(rst), .Start(start8), .Key(key), .Iv(iv), .Encrypt(encrypt),
        .Idle(idle8), .Error(err8), .S_axis(s8), .M_axis(m8)
    );

    aes256_ctr_axis_framer #(.AXIS_WIDTH(32)) dut32 (
        .Clk(clk), .Rst(rst), .Start(start32), .Key(key), .Iv(iv), .Encrypt(encrypt),
        .Idle(idle32), .Error(err32), .S_axis(s32), .M_axis(m32)
    );

    // Record every M handshake of both instances.
    always @(negedge clk) begin
        if (m8.tvalid && m8.tready) q8.push_back({m8.tuser, m8.tlast, m8.tkeep, m8.tdata});
        if (m32.tvalid && m32.tready) q32.push_back({m32.tuser, m32.tlast, m32.tkeep, m32.tdata});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [7:0] kb, input logic [7:0] ib);
        for (int k = 0; k < 32; k++) key[8*k +: 8] = kb + 8'(k);
        for (int k = 0; k < 16; k++) iv[8*k +: 8] = ib + 8'(k);
    endtask

    task automatic fill_expb(input logic [7:0] kb, input logic [7:0] ib);
        for (int k = 0; k < 32; k++) expb[k] = kb + 8'(k);
        for (int k = 0; k < 16; k++) expb[32+k] = ib + 8'(k);
    endtask

    task automatic pulse8();
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
    endtask

    task automatic pulse32();
        @(posedge clk); #1 start32 = 1'b1;
        @(posedge clk); #1 start32 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d, input logic l);
        int c;
        s8.tvalid = 1'b1; s8.tdata = d; s8.tkeep = 1'b1; s8.tlast = l;
        c = 0;
        @(negedge clk);
        while (!s8.tready && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_eq("s8_ready_wait", s8.tready, 1'b1);
        @(posedge clk); #1;
        s8.tvalid = 1'b0; s8.tlast = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic l);
        int c;
        s32.tvalid = 1'b1; s32.tdata = d; s32.tkeep = k; s32.tlast = l;
        c = 0;
        @(negedge clk);
        while (!s32.tready && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_eq("s32_ready_wait", s32.tready, 1'b1);
        @(posedge clk); #1;
        s32.tvalid = 1'b0; s32.tlast = 1'b0;
    endtask

    task automatic check_frame8(input string tag, input int n, input logic user);
        logic [10:0] e;
        check_eq({tag, "_len"}, q8.size(), n);
        for (int i = 0; i < n && i < q8.size(); i++) begin
            e = q8[i];
            check_eq($sformatf("%s_b%0d", tag, i), e, {user, (i == n-1), 1'b1, expb[i]});
        end
    endtask

    task automatic check_frame32(input string tag, input int n, input logic user);
        logic [37:0] e;
        check_eq({tag, "_len"}, q32.size(), n);
        for (int i = 0; i < n && i < q32.size(); i++) begin
            e = q32[i];
            check_eq($sformatf("%s_w%0d", tag, i), e,
                     {user, (i == n-1), 4'hf, expb[4*i+3], expb[4*i+2], expb[4*i+1], expb[4*i]});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] e;
        rst = 1'b1; start8 = 1'b0; start32 = 1'b0; encrypt = 1'b0; key = '0; iv = '0;
        s8.tvalid = 1'b0; s8.tdata = '0; s8.tkeep = '0; s8.tlast = 1'b0; s8.tuser = 1'b0;
        s32.tvalid = 1'b0; s32.tdata = '0; s32.tkeep = '0; s32.tlast = 1'b0; s32.tuser = 1'b0;
        m8.tready = 1'b1; m32.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_idle8", idle8, 1'b1);
        check_eq("rst_err8", err8, 1'b0);
        check_eq("rst_mvalid8", m8.tvalid, 1'b0);
        check_eq("rst_sready8", s8.tready, 1'b0);
        check_eq("rst_idle32", idle32, 1'b1);
        check_eq("rst_mvalid32", m32.tvalid, 1'b0);

        // 8-bit frame; fields and mode change after capture must not leak in.
        set_fields(8'h00, 8'hf0);
        encrypt = 1'b1;
        pulse8();
        encrypt = 1'b0;
        set_fields(8'h5a, 8'h5a);
        @(negedge clk);
        check_eq("t1_lat_valid", m8.tvalid, 1'b1);
        check_eq("t1_lat_data", m8.tdata, 8'h00);
        send8(8'haa, 1'b0);
        send8(8'hbb, 1'b0);
        send8(8'hcc, 1'b1);
        check_eq("t1_idle_after", idle8, 1'b1);
        fill_expb(8'h00, 8'hf0);
        expb[48] = 8'haa; expb[49] = 8'hbb; expb[50] = 8'hcc;
        check_frame8("t1", 51, 1'b1);
        q8.delete();

        // Backpressure during the key words and a Start pulse mid-frame.
        set_fields(8'h40, 8'h80);
        encrypt = 1'b0;
        pulse8();
        for (int c = 0; c < 5; c++) begin
            m8.tready = pat3[c];
            if (c == 1) begin
                start8 = 1'b1;
                set_fields(8'h99, 8'h99);
            end
            if (c == 2) start8 = 1'b0;
            @(negedge clk);
            check_eq($sformatf("t3_hold_c%0d", c), m8.tdata, exp3[c]);
            @(posedge clk); #1;
        end
        m8.tready = 1'b1;
        send8(8'h11, 1'b0);
        send8(8'h22, 1'b1);
        fill_expb(8'h40, 8'h80);
        expb[48] = 8'h11; expb[49] = 8'h22;
        check_frame8("t3", 50, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("t3_stay_idle", idle8, 1'b1);
            check_eq("t3_no_valid", m8.tvalid, 1'b0);
        end
        q8.delete();

        // 32-bit frame with a 20-byte payload.
        set_fields(8'h00, 8'hf0);
        encrypt = 1'b1;
        pulse32();
        encrypt = 1'b0;
        for (int b = 0; b < 5; b++) begin
            send32({8'h50 + 8'(4*b+3), 8'h50 + 8'(4*b+2), 8'h50 + 8'(4*b+1), 8'h50 + 8'(4*b)},
                   4'hf, (b == 4));
        end
        check_eq("t2_idle_after", idle32, 1'b1);
        fill_expb(8'h00, 8'hf0);
        for (int i = 0; i < 20; i++) expb[48+i] = 8'h50 + 8'(i);
        check_frame32("t2", 17, 1'b1);
        if (q32.size() == 17) begin
            e = q32[0];
            check_eq("t2_beat0", e[31:0], 32'h03020100);
            e = q32[8];
            check_eq("t2_beat8", e[31:0], 32'hf3f2f1f0);
            e = q32[16];
            check_eq("t2_last_keep", e[35:32], 4'hf);
        end
        q32.delete();

        // Legal partial last beat: forwarded, no error.
        pulse32();
        send32(32'h11223344, 4'hf, 1'b0);
        send32(32'h00005566, 4'h3, 1'b1);
        check_eq("t5a_len", q32.size(), 14);
        if (q32.size() == 14) begin
            e = q32[13];
            check_eq("t5a_last_beat", e, {1'b0, 1'b1, 4'h3, 32'h00005566});
        end
        check_eq("t5a_err", err32, 1'b0);
        q32.delete();

        // Non-last partial beat, then an empty last beat.
        pulse32();
        send32(32'h00aabbcc, 4'h7, 1'b0);
        send32(32'h00000000, 4'h0, 1'b1);
        check_eq("t5b_len", q32.size(), 14);
        if (q32.size() == 14) begin
            e = q32[12];
            check_eq("t5b_beat12", e, {1'b0, 1'b0, 4'h7, 32'h00aabbcc});
            e = q32[13];
            check_eq("t5b_beat13", e, {1'b0, 1'b1, 4'h0, 32'h00000000});
        end
        check_eq("t5b_err", err32, EXP_ERR);
        repeat (3) @(posedge clk);
        #1 check_eq("t5b_err_sticky", err32, EXP_ERR);
        check_eq("t5b_err8", err8, 1'b0);
        q32.delete();

        // Reset on IV word 2 of 4, then a fresh frame with a new key.
        set_fields(8'h00, 8'hf0);
        encrypt = 1'b1;
        pulse32();
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("t4_iv2_word", m32.tdata, 32'hfbfaf9f8);
        @(posedge clk); #1 rst = 1'b0;
        q32.delete();
        @(negedge clk);
        check_eq("t4_rst_idle", idle32, 1'b1);
        check_eq("t4_rst_mvalid", m32.tvalid, 1'b0);
        check_eq("t4_rst_sready", s32.tready, 1'b0);
        check_eq("t4_rst_err", err32, 1'b0);
        set_fields(8'hc0, 8'hf0);
        encrypt = 1'b0;
        pulse32();
        send32(32'hdeadbeef, 4'hf, 1'b1);
        fill_expb(8'hc0, 8'hf0);
        expb[48] = 8'hef; expb[49] = 8'hbe; expb[50] = 8'had; expb[51] = 8'hde;
        check_frame32("t4", 13, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
